// File: rtl/branch_resolve_if.sv
// branch_resolve_if: EX-stage branch resolution bundle.
//   master : driven by the pipeline/comparator side (EX operands, comparator
//            results, fetch PC) and consumes redirect/flush/prediction.
//   slave  : the branch_resolve block.
//   Signals: ex_* (EX instruction), br_un/br_eq/br_l (comparator link),
//            if_pc/if_pred_taken (BHT lookup), redirect_valid/redirect_pc/flush.
interface branch_resolve_if #(parameter int XLEN = 32);
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [2:0]      ex_funct3;
  logic            ex_is_branch;
  logic            ex_is_jal;
  logic            ex_is_jalr;
  logic [XLEN-1:0] ex_imm;
  logic [XLEN-1:0] ex_rs1;
  logic            ex_pred_taken;
  logic            br_un;
  logic            br_eq;
  logic            br_l;
  logic [XLEN-1:0] if_pc;
  logic            if_pred_taken;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            flush;

  modport master (
    output ex_valid, ex_pc, ex_funct3, ex_is_branch, ex_is_jal, ex_is_jalr,
           ex_imm, ex_rs1, ex_pred_taken, br_eq, br_l, if_pc,
    input  br_un, if_pred_taken, redirect_valid, redirect_pc, flush
  );

  modport slave (
    input  ex_valid, ex_pc, ex_funct3, ex_is_branch, ex_is_jal, ex_is_jalr,
           ex_imm, ex_rs1, ex_pred_taken, br_eq, br_l, if_pc,
    output br_un, if_pred_taken, redirect_valid, redirect_pc, flush
  );
endinterface

// File: rtl/branch_resolve.sv
// branch_resolve: EX-stage branch resolution.
//   Decodes funct3 against comparator results, computes branch/JAL/JALR
//   targets, detects mispredicts, issues a registered redirect pulse and a
//   2-cycle flush, and owns a BHT of 2-bit saturating counters for fetch.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         branch_resolve_if.slave (EX inputs, comparator link,
//               BHT lookup, redirect/flush outputs)
//   stat_branches_o / stat_mispredicts_o  only when BR_STATS_EN is defined
// Configuration macro: BR_STATS_EN (branch / mispredict counters).
module branch_resolve #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  branch_resolve_if.slave   bus
`ifdef BR_STATS_EN
  ,
  output logic [31:0]       stat_branches_o,
  output logic [31:0]       stat_mispredicts_o
`endif
);
  localparam int IDX_W = $clog2(BHT_ENTRIES);

  typedef enum logic [1:0] {IDLE, FLUSH1, FLUSH2} state_t;

  state_t          state_q;
  logic            redirect_valid_q;
  logic [XLEN-1:0] redirect_pc_q;
  logic [XLEN-1:0] redirect_pc_d;
  logic            flush_q;
  logic [1:0]      bht_q [BHT_ENTRIES];

  logic            legal, cond, act, is_jump, br_upd, mispredict;
  logic [XLEN-1:0] br_tgt, jalr_sum, jalr_tgt, fall_pc;
  logic [IDX_W-1:0] ex_idx, if_idx;

  assign bus.br_un = bus.ex_funct3[1];

  // funct3 01x has no branch encoding
  assign legal = (bus.ex_funct3[2:1] != 2'b01);

  always_comb begin
    cond = 1'b0;
    case (bus.ex_funct3)
      3'b000:         cond = bus.br_eq;
      3'b001:         cond = ~bus.br_eq;
      3'b100, 3'b110: cond = bus.br_l;
      3'b101, 3'b111: cond = ~bus.br_l;
      default:        cond = 1'b0;
    endcase
  end

  assign act        = bus.ex_valid & (state_q == IDLE);
  assign is_jump    = bus.ex_is_jal | bus.ex_is_jalr;
  assign br_upd     = act & bus.ex_is_branch & legal;
  assign mispredict = act & (is_jump | (bus.ex_is_branch & legal & (cond != bus.ex_pred_taken)));

  assign br_tgt   = bus.ex_pc + bus.ex_imm;
  assign jalr_sum = bus.ex_rs1 + bus.ex_imm;
  assign jalr_tgt = {jalr_sum[XLEN-1:1], 1'b0};
  assign fall_pc  = bus.ex_pc + XLEN'(4);

  assign redirect_pc_d = bus.ex_is_jalr                 ? jalr_tgt :
                         (bus.ex_is_jal | cond)         ? br_tgt   : fall_pc;

  assign ex_idx = bus.ex_pc[IDX_W+1:2];
  assign if_idx = bus.if_pc[IDX_W+1:2];

  // Read before the edge, so a same-cycle update is not visible yet
  assign bus.if_pred_taken  = bht_q[if_idx][1];
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.flush          = flush_q;

  // Redirect/flush sequencer; outputs are registered alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
    end else begin
      redirect_valid_q <= mispredict;
      if (mispredict) redirect_pc_q <= redirect_pc_d;
      case (state_q)
        IDLE: begin
          if (mispredict) begin
            state_q <= FLUSH1;
            flush_q <= 1'b1;
          end
        end
        FLUSH1: begin
          state_q <= FLUSH2;
          flush_q <= 1'b1;
        end
        FLUSH2: begin
          state_q <= IDLE;
          flush_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          flush_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    end else if (br_upd) begin
      if (cond) begin
        if (bht_q[ex_idx] != 2'b11) bht_q[ex_idx] <= bht_q[ex_idx] + 2'b01;
      end else begin
        if (bht_q[ex_idx] != 2'b00) bht_q[ex_idx] <= bht_q[ex_idx] - 2'b01;
      end
    end
  end

`ifdef BR_STATS_EN
  logic [31:0] stat_br_q, stat_mp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else if (br_upd) begin
      stat_br_q <= stat_br_q + 32'd1;
      if (cond != bus.ex_pred_taken) stat_mp_q <= stat_mp_q + 32'd1;
    end
  end

  assign stat_branches_o    = stat_br_q;
  assign stat_mispredicts_o = stat_mp_q;
`endif
endmodule

// File: tb/tb_branch_resolve.sv
module tb_branch_resolve;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_resolve_if #(.XLEN(XLEN)) bus ();

  // Comparator stand-in: operands live in the bench, results follow br_un
  logic [31:0] op_a, op_b;
  assign bus.br_eq = (op_a == op_b);
  assign bus.br_l  = bus.br_un ? (op_a < op_b) : ($signed(op_a) < $signed(op_b));

`ifdef BR_STATS_EN
  logic [31:0] st_br, st_mp;
`endif

  branch_resolve #(.XLEN(XLEN), .BHT_ENTRIES(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef BR_STATS_EN
    ,
    .stat_branches_o    (st_br),
    .stat_mispredicts_o (st_mp)
`endif
  );

  int vectors = 0;
  int miscompares = 0;
  bit started = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  logic [1:0]  m_bht [16];
  int          flush_left;
  logic        m_rv;
  logic [31:0] m_rpc;
  logic [31:0] m_nbr, m_nmp;

  function automatic bit legal3(input logic [2:0] f3);
    return !(f3 == 3'd2 || f3 == 3'd3);
  endfunction

  function automatic bit ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return !($signed(a) < $signed(b));
      3'd6: return a < b;
      3'd7: return !(a < b);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] sat(input logic [1:0] c, input bit tk);
    int v;
    v = int'(c) + (tk ? 1 : -1);
    if (v > 3) v = 3;
    if (v < 0) v = 0;
    return 2'(v);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) m_bht[i] <= 2'b01;
      flush_left <= 0;
      m_rv <= 1'b0;
      m_rpc <= '0;
      m_nbr <= '0;
      m_nmp <= '0;
    end else begin
      m_rv <= 1'b0;
      if (flush_left != 0) flush_left <= flush_left - 1;
      else if (bus.ex_valid) begin
        if (bus.ex_is_jal || bus.ex_is_jalr) begin
          m_rv <= 1'b1;
          m_rpc <= bus.ex_is_jalr ? ((bus.ex_rs1 + bus.ex_imm) & 32'hFFFF_FFFE)
                                  : (bus.ex_pc + bus.ex_imm);
          flush_left <= 2;
        end else if (bus.ex_is_branch && legal3(bus.ex_funct3)) begin
          m_bht[bus.ex_pc[5:2]] <= sat(m_bht[bus.ex_pc[5:2]], ref_taken(bus.ex_funct3, op_a, op_b));
          m_nbr <= m_nbr + 1;
          if (ref_taken(bus.ex_funct3, op_a, op_b) != bus.ex_pred_taken) begin
            m_rv <= 1'b1;
            m_rpc <= ref_taken(bus.ex_funct3, op_a, op_b) ? (bus.ex_pc + bus.ex_imm) : (bus.ex_pc + 32'd4);
            flush_left <= 2;
            m_nmp <= m_nmp + 1;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (started) begin
      chk("br_un", {31'd0, bus.br_un}, {31'd0, bus.ex_funct3[1]});
      chk("if_pred_taken", {31'd0, bus.if_pred_taken}, {31'd0, m_bht[bus.if_pc[5:2]][1]});
      chk("redirect_valid", {31'd0, bus.redirect_valid}, {31'd0, m_rv});
      if (m_rv) chk("redirect_pc", bus.redirect_pc, m_rpc);
      chk("flush", {31'd0, bus.flush}, {31'd0, (flush_left != 0)});
`ifdef BR_STATS_EN
      chk("stat_branches", st_br, m_nbr);
      chk("stat_mispredicts", st_mp, m_nmp);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic drv(input bit v, input logic [31:0] pc, input logic [2:0] f3, input int kind,
                     input logic [31:0] imm, input logic [31:0] rs1, input bit pred,
                     input logic [31:0] a, input logic [31:0] b);
    bus.ex_valid      = v;
    bus.ex_pc         = pc;
    bus.ex_funct3     = f3;
    bus.ex_is_branch  = (kind == 0);
    bus.ex_is_jal     = (kind == 1);
    bus.ex_is_jalr    = (kind == 2);
    bus.ex_imm        = imm;
    bus.ex_rs1        = rs1;
    bus.ex_pred_taken = pred;
    op_a = a;
    op_b = b;
  endtask

  task automatic idle();
    drv(1'b0, 32'h0, 3'd0, 3, 32'h0, 32'h0, 1'b0, 32'h0, 32'h1);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  logic [1:0] sat_seq [4];
  logic [31:0] pool [5];

  initial begin
    idle();
    bus.if_pc = 32'h40;
    #1;
    started = 1'b1;
    // 1: reset state
    chk("rst_pred", {31'd0, bus.if_pred_taken}, 32'd0);
    chk("rst_rv", {31'd0, bus.redirect_valid}, 32'd0);
    chk("rst_rpc", bus.redirect_pc, 32'd0);
    chk("rst_flush", {31'd0, bus.flush}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // 2: BEQ taken, predicted not taken
    drv(1'b1, 32'h100, 3'd0, 0, 32'h20, 32'h0, 1'b0, 32'd5, 32'd5);
    bus.if_pc = 32'h100;
    chk("beq_br_un", {31'd0, bus.br_un}, 32'd0);
    tick();
    chk("beq_rv", {31'd0, bus.redirect_valid}, 32'd1);
    chk("beq_rpc", bus.redirect_pc, 32'h120);
    chk("beq_flush1", {31'd0, bus.flush}, 32'd1);
    chk("beq_model_bht0", {30'd0, m_bht[0]}, 32'd2);
    chk("beq_pred_ctr2", {31'd0, bus.if_pred_taken}, 32'd1);
    idle();
    tick();
    chk("beq_rv_pulse", {31'd0, bus.redirect_valid}, 32'd0);
    chk("beq_flush2", {31'd0, bus.flush}, 32'd1);
    tick();
    chk("beq_flush_end", {31'd0, bus.flush}, 32'd0);

    // 3: BLTU drives unsigned compare; BGE signed not taken vs pred 1; BLT correct
    drv(1'b0, 32'h0, 3'b110, 0, 32'h0, 32'h0, 1'b0, 32'd0, 32'd0);
    #1 chk("bltu_br_un", {31'd0, bus.br_un}, 32'd1);
    drv(1'b1, 32'h208, 3'b101, 0, 32'h40, 32'h0, 1'b1, 32'hFFFF_FFFB, 32'd3);
    tick();
    chk("bge_rv", {31'd0, bus.redirect_valid}, 32'd1);
    chk("bge_rpc", bus.redirect_pc, 32'h20C);
    idle();
    tick();
    tick();
    drv(1'b1, 32'h304, 3'b100, 0, 32'h40, 32'h0, 1'b1, 32'd1, 32'd2);
    tick();
    chk("blt_no_rv", {31'd0, bus.redirect_valid}, 32'd0);
    chk("blt_no_flush", {31'd0, bus.flush}, 32'd0);

    // 4: JALR target LSB cleared; branch during flush ignored
    drv(1'b1, 32'h400, 3'd0, 2, 32'd4, 32'h1003, 1'b0, 32'd0, 32'd1);
    tick();
    chk("jalr_rv", {31'd0, bus.redirect_valid}, 32'd1);
    chk("jalr_rpc", bus.redirect_pc, 32'h1006);
    drv(1'b1, 32'h0, 3'd0, 0, 32'h80, 32'h0, 1'b0, 32'd7, 32'd7);
    tick();
    chk("ign_rv1", {31'd0, bus.redirect_valid}, 32'd0);
    chk("ign_bht1", {30'd0, m_bht[0]}, 32'd2);
    tick();
    chk("ign_rv2", {31'd0, bus.redirect_valid}, 32'd0);
    chk("ign_bht2", {30'd0, m_bht[0]}, 32'd2);
    idle();
    tick();

    // 5: saturation on index 5
    sat_seq[0] = 2'd2; sat_seq[1] = 2'd3; sat_seq[2] = 2'd3; sat_seq[3] = 2'd3;
    for (int k = 0; k < 4; k++) begin
      drv(1'b1, 32'h14, 3'd0, 0, 32'h10, 32'h0, 1'b1, 32'd9, 32'd9);
      tick();
      chk("sat_model", {30'd0, m_bht[5]}, {30'd0, sat_seq[k]});
      chk("sat_no_rv", {31'd0, bus.redirect_valid}, 32'd0);
    end
    drv(1'b1, 32'h14, 3'd0, 0, 32'h10, 32'h0, 1'b1, 32'd9, 32'd8);
    tick();
    chk("sat_dec_model", {30'd0, m_bht[5]}, 32'd2);
    chk("sat_dec_rpc", bus.redirect_pc, 32'h18);
    idle();
    tick();
    tick();
    bus.if_pc = 32'h14;
    drv(1'b1, 32'h14, 3'b010, 0, 32'h10, 32'h0, 1'b0, 32'd9, 32'd9);
    tick();
    chk("illegal_no_rv", {31'd0, bus.redirect_valid}, 32'd0);
    chk("illegal_no_flush", {31'd0, bus.flush}, 32'd0);
    chk("illegal_bht", {30'd0, m_bht[5]}, 32'd2);
    chk("idx5_pred", {31'd0, bus.if_pred_taken}, 32'd1);

    // 6: reset during FLUSH1
    drv(1'b1, 32'h500, 3'd0, 1, 32'h40, 32'h0, 1'b0, 32'd0, 32'd0);
    tick();
    chk("jal_rpc", bus.redirect_pc, 32'h540);
    chk("jal_flush", {31'd0, bus.flush}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_flush", {31'd0, bus.flush}, 32'd0);
    chk("rst_mid_rv", {31'd0, bus.redirect_valid}, 32'd0);
    chk("rst_mid_bht", {31'd0, bus.if_pred_taken}, 32'd0);
    idle();
    tick();
    rst_n = 1'b1;
    tick();

`ifdef BR_STATS_EN
    chk("stat_br_rst", st_br, 32'd0);
    chk("stat_mp_rst", st_mp, 32'd0);
    drv(1'b1, 32'h18, 3'd0, 0, 32'h8, 32'h0, 1'b1, 32'd3, 32'd3);
    tick();
    drv(1'b1, 32'h1C, 3'd0, 0, 32'h8, 32'h0, 1'b0, 32'd3, 32'd4);
    tick();
    drv(1'b1, 32'h20, 3'd1, 0, 32'h8, 32'h0, 1'b0, 32'd3, 32'd4);
    tick();
    idle();
    tick();
    tick();
    chk("stat_br_3", st_br, 32'd3);
    chk("stat_mp_1", st_mp, 32'd1);
`endif

    // Randomized phase
    pool[0] = 32'h0; pool[1] = 32'h1; pool[2] = 32'hFFFF_FFFF; pool[3] = 32'h8000_0000; pool[4] = 32'h7FFF_FFFF;
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a, b;
      int kind;
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
      a = ($urandom_range(0, 1) != 0) ? pool[$urandom_range(0, 4)] : $urandom();
      b = ($urandom_range(0, 3) == 0) ? a :
          (($urandom_range(0, 1) != 0) ? pool[$urandom_range(0, 4)] : $urandom());
      kind = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 3));
      drv(1'($urandom_range(0, 3) != 0), {24'h0, 6'($urandom()), 2'b00}, 3'($urandom()), kind,
          $urandom(), $urandom(), 1'($urandom()), a, b);
      bus.if_pc = $urandom();
      tick();
    end
    rst_n = 1'b1;
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
